// File: rtl/btn_debounce_if.sv
// Button bus between raw pins and the debounced level consumers.
// The debouncer is the slave; whatever drives the pins is the master.
interface btn_debounce_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] btn_raw;
    logic [WIDTH-1:0] btn_clean;
    logic [WIDTH-1:0] btn_busy;

    modport master (
        output btn_raw,
        input  btn_clean,
        input  btn_busy
    );

    modport slave (
        input  btn_raw,
        output btn_clean,
        output btn_busy
    );
endinterface

// File: rtl/btn_debounce.sv
// Per-bit synchronizer plus counting debouncer for mechanical push buttons.
// Each bit owns its own synchronizer, counter and LOW/RISE/HIGH/FALL state.
module btn_debounce #(
    parameter int unsigned WIDTH           = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    btn_debounce_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_RISE = 2'd1,
        ST_HIGH = 2'd2,
        ST_FALL = 2'd3
    } state_t;

    generate
        if (WIDTH < 1 || DEBOUNCE_CYCLES < 1 || SYNC_STAGES < 2) begin : g_bad_params
            $error("btn_debounce: WIDTH>=1, DEBOUNCE_CYCLES>=1 and SYNC_STAGES>=2 are required");
        end
    endgenerate

    logic [WIDTH-1:0] pressed;
    logic [WIDTH-1:0] clean_v;
    logic [WIDTH-1:0] busy_v;

    // Normalise polarity so 1 always means pressed from here on.
    assign pressed = ACTIVE_LOW ? ~bus.btn_raw : bus.btn_raw;

    generate
        for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
            logic [SYNC_STAGES-1:0] sync_q;
            logic                   s;
            state_t                 state;
            logic [CNT_W-1:0]       cnt;
            logic                   clean_q;
            logic                   busy_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], pressed[i]};
                end
            end

            assign s = sync_q[SYNC_STAGES-1];

            // Outputs are written alongside the state so they track the next state.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state   <= ST_LOW;
                    cnt     <= '0;
                    clean_q <= 1'b0;
                    busy_q  <= 1'b0;
                end else begin
                    case (state)
                        ST_LOW: begin
                            if (s) begin
                                if (DEBOUNCE_CYCLES == 1) begin
                                    state   <= ST_HIGH;
                                    cnt     <= '0;
                                    clean_q <= 1'b1;
                                    busy_q  <= 1'b0;
                                end else begin
                                    state   <= ST_RISE;
                                    cnt     <= CNT_ONE;
                                    clean_q <= 1'b0;
                                    busy_q  <= 1'b1;
                                end
                            end
                        end
                        ST_RISE: begin
                            if (!s) begin
                                state   <= ST_LOW;
                                cnt     <= '0;
                                clean_q <= 1'b0;
                                busy_q  <= 1'b0;
                            end else if (cnt == CNT_LAST) begin
                                state   <= ST_HIGH;
                                cnt     <= '0;
                                clean_q <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end
                        ST_HIGH: begin
                            if (!s) begin
                                if (DEBOUNCE_CYCLES == 1) begin
                                    state   <= ST_LOW;
                                    cnt     <= '0;
                                    clean_q <= 1'b0;
                                    busy_q  <= 1'b0;
                                end else begin
                                    state   <= ST_FALL;
                                    cnt     <= CNT_ONE;
                                    clean_q <= 1'b1;
                                    busy_q  <= 1'b1;
                                end
                            end
                        end
                        ST_FALL: begin
                            if (s) begin
                                state   <= ST_HIGH;
                                cnt     <= '0;
                                clean_q <= 1'b1;
                                busy_q  <= 1'b0;
                            end else if (cnt == CNT_LAST) begin
                                state   <= ST_LOW;
                                cnt     <= '0;
                                clean_q <= 1'b0;
                                busy_q  <= 1'b0;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end
                        default: begin
                            state   <= ST_LOW;
                            cnt     <= '0;
                            clean_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    endcase
                end
            end

            assign clean_v[i] = clean_q;
            assign busy_v[i]  = busy_q;
        end
    endgenerate

    assign bus.btn_clean = clean_v;
    assign bus.btn_busy  = busy_v;

endmodule
